// File: rtl/capture_mc.sv
// capture_mc: multi-channel pulse-timing capture.
// Measures high time, low time and period (in clk cycles) of NUM_CH
// asynchronous inputs and publishes one result word at a time on a shared
// output register, chosen round-robin among channels with a pending result.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        asynchronous, active-high reset
//   signal_in  [NUM_CH] asynchronous inputs, bit i = channel i
//   ch_en      [NUM_CH] per-channel enable; 0 idles the channel and drops
//              its pending result
//   res_valid  result word present
//   res_ready  consumer accepts the word
//   res_ch     channel index of the word
//   res_high   high-level cycles
//   res_low    low-level cycles
//   res_period res_high + res_low, saturated
//   res_flags  [2]=overrun, [1]=timeout, [0]=stuck level (meaningful with [1])
//
// Handshake: a word transfers on every rising clk edge where
// res_valid & res_ready. While res_valid=1 and res_ready=0 all res_* hold
// their value, and res_valid only falls after a transfer (or reset).
module capture_mc #(
  parameter int     NUM_CH  = 4,
  parameter int     CNT_W   = 32,
  parameter longint TIMEOUT = 50000000,
  localparam int    CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] signal_in,
  input  logic [NUM_CH-1:0] ch_en,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CH_W-1:0]   res_ch,
  output logic [CNT_W-1:0]  res_high,
  output logic [CNT_W-1:0]  res_low,
  output logic [CNT_W-1:0]  res_period,
  output logic [2:0]        res_flags
);

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
  localparam bit               TO_EN  = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } ch_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Sum is formed one bit wider so a carry-out can be clamped to all-ones.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // Synchronizer and edge detect
  logic [NUM_CH-1:0] sync0, sync1, prev_lvl, rise, fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0    <= '0;
      sync1    <= '0;
      prev_lvl <= '0;
    end else begin
      sync0    <= signal_in;
      sync1    <= sync0;
      prev_lvl <= sync1;
    end
  end

  assign rise = sync1 & ~prev_lvl;
  assign fall = ~sync1 & prev_lvl;

  // Per-channel measurement FSMs (ch_state is the observable state vector)
  ch_state_t        ch_state    [NUM_CH];
  ch_state_t        ch_state_nx [NUM_CH];
  logic [CNT_W-1:0] hcnt        [NUM_CH];
  logic [CNT_W-1:0] hcnt_nx     [NUM_CH];
  logic [CNT_W-1:0] lcnt        [NUM_CH];
  logic [CNT_W-1:0] lcnt_nx     [NUM_CH];
  logic [CNT_W-1:0] hold_high   [NUM_CH];
  logic [CNT_W-1:0] hold_nx     [NUM_CH];

  logic [NUM_CH-1:0] emit, emit_to, emit_lvl;
  logic [CNT_W-1:0]  emit_high   [NUM_CH];
  logic [CNT_W-1:0]  emit_low    [NUM_CH];
  logic [CNT_W-1:0]  emit_period [NUM_CH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        ch_state[i]  <= ST_IDLE;
        hcnt[i]      <= '0;
        lcnt[i]      <= '0;
        hold_high[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        ch_state[i]  <= ch_state_nx[i];
        hcnt[i]      <= hcnt_nx[i];
        lcnt[i]      <= lcnt_nx[i];
        hold_high[i] <= hold_nx[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_state_nx[i] = ch_state[i];
      hcnt_nx[i]     = hcnt[i];
      lcnt_nx[i]     = lcnt[i];
      hold_nx[i]     = hold_high[i];
      emit[i]        = 1'b0;
      emit_to[i]     = 1'b0;
      emit_lvl[i]    = 1'b0;
      emit_high[i]   = hold_high[i];
      emit_low[i]    = lcnt[i];
      emit_period[i] = sat_add(hold_high[i], lcnt[i]);
      if (!ch_en[i]) begin
        ch_state_nx[i] = ST_IDLE;
        hcnt_nx[i]     = '0;
        lcnt_nx[i]     = '0;
        hold_nx[i]     = '0;
      end else begin
        case (ch_state[i])
          // Falls are ignored here: a measurement always opens on a rise.
          ST_IDLE: begin
            if (rise[i]) begin
              ch_state_nx[i] = ST_HIGH;
              hcnt_nx[i]     = CNT_W'(1);
            end
          end
          // An edge in the same cycle takes priority over the timeout.
          ST_HIGH: begin
            if (fall[i]) begin
              ch_state_nx[i] = ST_LOW;
              hold_nx[i]     = hcnt[i];
              lcnt_nx[i]     = CNT_W'(1);
            end else if (TO_EN && hcnt[i] == TO_VAL) begin
              emit[i]        = 1'b1;
              emit_to[i]     = 1'b1;
              emit_lvl[i]    = sync1[i];
              emit_high[i]   = hcnt[i];
              emit_low[i]    = '0;
              emit_period[i] = '0;
              ch_state_nx[i] = ST_IDLE;
              hcnt_nx[i]     = '0;
              lcnt_nx[i]     = '0;
              hold_nx[i]     = '0;
            end else begin
              hcnt_nx[i] = sat_inc(hcnt[i]);
            end
          end
          ST_LOW: begin
            if (rise[i]) begin
              emit[i]        = 1'b1;
              ch_state_nx[i] = ST_HIGH;
              hcnt_nx[i]     = CNT_W'(1);
            end else if (TO_EN && lcnt[i] == TO_VAL) begin
              emit[i]        = 1'b1;
              emit_to[i]     = 1'b1;
              emit_lvl[i]    = sync1[i];
              emit_period[i] = '0;
              ch_state_nx[i] = ST_IDLE;
              hcnt_nx[i]     = '0;
              lcnt_nx[i]     = '0;
              hold_nx[i]     = '0;
            end else begin
              lcnt_nx[i] = sat_inc(lcnt[i]);
            end
          end
          default: ch_state_nx[i] = ST_IDLE;
        endcase
      end
    end
  end

  // Round-robin arbiter over pending slots
  logic [NUM_CH-1:0] pend_valid, req, taken;
  logic [CNT_W-1:0]  pend_high   [NUM_CH];
  logic [CNT_W-1:0]  pend_low    [NUM_CH];
  logic [CNT_W-1:0]  pend_period [NUM_CH];
  logic [2:0]        pend_flags  [NUM_CH];

  logic            load, take, grant_valid;
  logic [CH_W-1:0] grant_idx, rr_ptr, scan_idx;
  logic [CH_W:0]   scan;

  assign req  = pend_valid & ch_en;
  assign load = ~res_valid | res_ready;
  assign take = load & grant_valid;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan        = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      scan = {1'b0, rr_ptr} + (CH_W+1)'(k);
      if (scan >= (CH_W+1)'(NUM_CH)) scan = scan - (CH_W+1)'(NUM_CH);
      scan_idx = scan[CH_W-1:0];
      if (!grant_valid && req[scan_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    taken = '0;
    if (take) taken[grant_idx] = 1'b1;
  end

  // Pending slots: a new result overwrites an undrained one and marks overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        pend_high[i]   <= '0;
        pend_low[i]    <= '0;
        pend_period[i] <= '0;
        pend_flags[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!ch_en[i]) begin
          pend_valid[i] <= 1'b0;
        end else if (emit[i]) begin
          pend_valid[i]  <= 1'b1;
          pend_high[i]   <= emit_high[i];
          pend_low[i]    <= emit_low[i];
          pend_period[i] <= emit_period[i];
          pend_flags[i]  <= {pend_valid[i] & ~taken[i], emit_to[i], emit_lvl[i]};
        end else if (taken[i]) begin
          pend_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid  <= 1'b0;
      res_ch     <= '0;
      res_high   <= '0;
      res_low    <= '0;
      res_period <= '0;
      res_flags  <= '0;
      rr_ptr     <= '0;
    end else if (load) begin
      res_valid <= grant_valid;
      if (grant_valid) begin
        res_ch     <= grant_idx;
        res_high   <= pend_high[grant_idx];
        res_low    <= pend_low[grant_idx];
        res_period <= pend_period[grant_idx];
        res_flags  <= pend_flags[grant_idx];
        rr_ptr     <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
      end
    end
  end

endmodule

// File: doc/capture_mc.md
# capture_mc

Multi-channel pulse-timing capture unit: measures high time, low time and period of up to NUM_CH asynchronous digital inputs in system-clock cycles. It replaces the single-channel capture in the frequency-counter datapath and feeds a shared result stream that the readout logic drains with a valid/ready handshake. Over the single-channel design it adds per-channel enables, a stuck-signal timeout, counter saturation, overrun reporting and round-robin result arbitration.

## Interface
- NUM_CH, 4, number of input channels (1..16)
- CNT_W, 32, width of high/low/period counters and results
- TIMEOUT, 50000000, cycles in one level before a channel is declared stuck; 0 disables; must be ≤ 2^CNT_W−1
- CH_W, max(1,$clog2(NUM_CH)), derived localparam, channel index width
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- signal_in  in  NUM_CH  asynchronous inputs to measure, bit i = channel i
- ch_en  in  NUM_CH  per-channel enable, synchronous to clk
- res_valid  out  1  result word present
- res_ready  in  1  consumer accepts result when res_valid & res_ready
- res_ch  out  CH_W  channel index of result
- res_high  out  CNT_W  high-level cycles
- res_low  out  CNT_W  low-level cycles
- res_period  out  CNT_W  res_high+res_low, saturated to 2^CNT_W−1
- res_flags  out  3  [2]=overrun, [1]=timeout, [0]=level stuck at (valid only with [1])

## Operation
- Per channel: 2-FF synchronizer s0→s1, then prev<=s1. rise = s1 & ~prev; fall = ~s1 & prev.
- Per-channel FSM IDLE / HIGH / LOW; reset and ch_en[i]=0 force IDLE, clear counters and the channel pending slot.
- IDLE: on rise → HIGH, hcnt<=1. Falls ignored (first measured period starts at a rising edge).
- HIGH: no fall → hcnt<=hcnt+1 (saturating at 2^CNT_W−1). On fall → LOW, hold_high<=hcnt, lcnt<=1.
- LOW: no rise → lcnt++ (saturating). On rise → emit result {hold_high, lcnt, sat(hold_high+lcnt), flags}, → HIGH, hcnt<=1.
- Timeout (TIMEOUT≠0): in HIGH when hcnt==TIMEOUT, or LOW when lcnt==TIMEOUT, and no edge that cycle → emit result high=hcnt or hold_high, low=lcnt or 0, period=0, flags[1]=1, flags[0]=current level; → IDLE. Edge in same cycle wins over timeout.
- Pending slot: one entry per channel. New result while slot full and not being drained this cycle → overwrite, set overrun flag in new entry. Slot drained same cycle as write → new entry stored, no overrun.
- Arbiter: single output register. Loaded when empty or popped this cycle (res_valid & res_ready). Grants the first full pending slot searching from (last granted +1) mod NUM_CH; after reset search starts at channel 0. Granted slot cleared on load.
- Period sum computed CNT_W+1 bits wide, saturated to CNT_W.

## Timing
- Reset values: res_valid=0, res_ch=0, res_high=0, res_low=0, res_period=0, res_flags=0; all FSMs IDLE, pending empty, RR pointer 0.
- Edge on signal_in sampled at clock edge E0 → detected during cycle after E1 → result in pending at E2 → output register at E3 (res_valid high after E3) if output empty or popped at E3.
- Sustained throughput: one result per cycle when res_ready=1.
- res_* stable while res_valid=1 and res_ready=0; res_valid never drops without a pop.
- ch_en deassert: channel idles at next edge; a result already in the output register is not retracted.
- Asynchronous rst mid-transfer: outputs to reset values immediately; in-flight results lost.
- Measurement granularity ±1 cycle from synchronization; constant 2-cycle latency cancels in high/low/period.

## Test plan
- Ch0 square wave 3 high / 5 low, res_ready=1 → after first rise, each period emits res_ch=0, high=3, low=5, period=8, flags=0.
- All 4 channels, identical phase-aligned waves → results appear in order ch0,1,2,3 on consecutive cycles, none with overrun.
- Ch1 toggling every 2 cycles, res_ready=0 for 20 cycles → released entry for ch1 has flags[2]=1 and latest values; output held stable throughout stall.
- TIMEOUT=100, ch2 rises then stays high → one result high=100, period=0, flags=3'b011; channel IDLE; next rise restarts measurement.
- CNT_W=8, TIMEOUT=0, 300-cycle high / 300-cycle low → high=255, low=255, period=255.
- Assert rst during active measurement with res_valid=1 → res_valid=0 immediately; after release first result requires a fresh full period.
